spi_dac_slave: RTL and testbench

- SPI responder (slave) for the DAC word stream: it takes the byte pair that the SPI master sends and rebuilds the 16-bit DAC word, MSB first.
- It sits in the i_Clk domain. The SPI pins are synchronised and oversampled; the block does not use SCLK as a clock.
- Used as the on-chip loopback/DAC model so firmware and the bench can check the DAC value that was actually sent against DAC_val.
- The word and a frame-error flag are also exported to the monitor register file.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_dac_slave.sv | 166 ++++++++++++++++
 tb/tb_spi_dac_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding, limits and sample-edge selection for the SPI DAC responder.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StCheck = 2'd2
  } spi_state_e;

  localparam int unsigned    CNT_W       = 6;
  localparam logic [7:0]     ERR_CNT_MAX = 8'd255;
  localparam logic [CNT_W-1:0] BIT_CNT_MAX = 6'd63;

  // Mode = {CPOL, CPHA}; MOSI is sampled on SCLK rising when CPOL == CPHA.
  function automatic logic sample_on_rise(input int unsigned mode);
    logic cpol;
    logic cpha;
    cpol = ((mode >> 1) & 32'd1) != 32'd0;
    cpha = (mode & 32'd1) != 32'd0;
    return (cpol ^ cpha) == 1'b0;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a history flop for rise/fall detection. Edges are
// suppressed until the chain has refilled after reset, so a level already present
// at reset release is never mistaken for a transition.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   valid_q;
  logic                   level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      hist_q  <= RESET_VAL;
      valid_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q  <= sync_q[SYNC_STAGES-1];
      valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_o = valid_q[SYNC_STAGES] & level & ~hist_q;
  assign fall_o = valid_q[SYNC_STAGES] & ~level & hist_q;

endmodule

// File: rtl/spi_dac_slave.sv
// SPI responder rebuilding the DAC word from oversampled SPI pins in the i_Clk domain.
// Define SPI_SLAVE_MISO_EN to shift the previous word back out on o_SPI_MISO.
module spi_dac_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE    = 0,
  parameter int unsigned WORD_BITS   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_SPI_Clk,
  input  logic                 i_SPI_MOSI,
  input  logic                 i_SPI_CS_n,
  output logic                 o_SPI_MISO,
  output logic [WORD_BITS-1:0] o_RX_Word,
  output logic                 o_RX_DV,
  output logic                 o_Frame_Err,
  output logic [7:0]           o_Err_Count,
  output logic                 o_Busy
);

  localparam logic             CPOL        = ((SPI_MODE >> 1) & 32'd1) != 32'd0;
  localparam logic             SAMPLE_RISE = sample_on_rise(SPI_MODE);
  localparam logic [CNT_W-1:0] WORD_CNT    = CNT_W'(WORD_BITS);

  spi_state_e             state_q, state_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic                   dv_q, dv_d;
  logic                   ferr_q, ferr_d;
  logic [7:0]             err_q, err_d;
  logic [SYNC_STAGES-1:0] mosi_q;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic sample_edge, mosi_s;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (CPOL)
  ) u_sclk_sync (
    .clk_i (i_Clk),
    .rst_ni(i_Rst_L),
    .d_i   (i_SPI_Clk),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_cs_sync (
    .clk_i (i_Clk),
    .rst_ni(i_Rst_L),
    .d_i   (i_SPI_CS_n),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  assign mosi_s      = mosi_q[SYNC_STAGES-1];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
      mosi_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
      err_q   <= err_d;
      mosi_q  <= {mosi_q[SYNC_STAGES-2:0], i_SPI_MOSI};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall) state_d = StShift;
      StShift: if (cs_rise) state_d = StCheck;
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      // A sample edge coinciding with the CS_n rise still counts.
      StShift: begin
        if (sample_edge) begin
          shift_d = {shift_q[WORD_BITS-2:0], mosi_s};
          cnt_d   = (cnt_q == BIT_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (cnt_q == WORD_CNT) begin
          word_d = shift_q;
          dv_d   = 1'b1;
        end else begin
          ferr_d = 1'b1;
          err_d  = (err_q == ERR_CNT_MAX) ? err_q : err_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_RX_Word   = word_q;
  assign o_RX_DV     = dv_q;
  assign o_Frame_Err = ferr_q;
  assign o_Err_Count = err_q;
  assign o_Busy      = (state_q != StIdle);

`ifdef SPI_SLAVE_MISO_EN
  logic [WORD_BITS-1:0] miso_q, miso_d;
  logic                 launch_edge;

  assign launch_edge = SAMPLE_RISE ? sclk_fall : sclk_rise;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      miso_q <= '0;
    end else begin
      miso_q <= miso_d;
    end
  end

  // The first launch edge of a CPHA=1 frame precedes any sample, so it presents the MSB
  // rather than shifting it away.
  always_comb begin
    miso_d = miso_q;
    if (state_q == StIdle && cs_fall) begin
      miso_d = word_q;
    end else if (state_q == StShift && launch_edge && cnt_q != '0) begin
      miso_d = {miso_q[WORD_BITS-2:0], 1'b0};
    end
  end

  assign o_SPI_MISO = (state_q == StShift) & miso_q[WORD_BITS-1];
`else
  assign o_SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_slave.sv
// Bench for spi_dac_slave: one instance per SPI mode, driven by bit-banged frames and
// checked against a frame-level model of received words and error counts.
module tb_spi_dac_slave;

  localparam int HALF   = 4;
  localparam int SETTLE = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sclk, mosi, cs_n;
  logic [3:0] miso, dv, ferr, busy;
  logic [15:0] word [4];
  logic [7:0]  errc [4];

  int n_tests = 0;
  int n_fail  = 0;

  int dv_cnt [4];
  int ferr_cnt [4];
  int both_cnt = 0;
  int miso_hi  = 0;

  logic [15:0] exp_word [4];
  int          exp_err  [4];
  int          exp_dv   [4];
  int          exp_ferr [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_dac_slave #(
      .SPI_MODE   (m),
      .WORD_BITS  (16),
      .SYNC_STAGES(2)
    ) u_dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_SPI_Clk  (sclk[m]),
      .i_SPI_MOSI (mosi[m]),
      .i_SPI_CS_n (cs_n[m]),
      .o_SPI_MISO (miso[m]),
      .o_RX_Word  (word[m]),
      .o_RX_DV    (dv[m]),
      .o_Frame_Err(ferr[m]),
      .o_Err_Count(errc[m]),
      .o_Busy     (busy[m])
    );
  end

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (dv[m]) dv_cnt[m]++;
      if (ferr[m]) ferr_cnt[m]++;
      if (dv[m] && ferr[m]) both_cnt++;
      if (cs_n[m] && miso[m]) miso_hi++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: only an exact 16-bit frame updates the word.
  task automatic model_frame(input int m, input logic [63:0] data, input int nbits);
    if (nbits == 16) begin
      exp_word[m] = data[15:0];
      exp_dv[m]++;
    end else begin
      exp_ferr[m]++;
      if (exp_err[m] < 255) exp_err[m]++;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      exp_word[m] = '0;
      exp_err[m]  = 0;
    end
  endtask

  task automatic check_all(input int m);
    check_eq($sformatf("word_m%0d", m), word[m], exp_word[m]);
    check_eq($sformatf("errc_m%0d", m), errc[m], exp_err[m]);
    check_eq($sformatf("dv_cycles_m%0d", m), dv_cnt[m], exp_dv[m]);
    check_eq($sformatf("ferr_cycles_m%0d", m), ferr_cnt[m], exp_ferr[m]);
    check_eq($sformatf("idle_busy_m%0d", m), busy[m], 1'b0);
  endtask

  task automatic send_bits(input int m, input logic [63:0] data, input int nbits,
                           input bit open, input bit close, output logic [63:0] rx);
    bit cpha;
    cpha = (m % 2) == 1;
    rx = '0;
    if (open) begin
      cs_n[m] = 1'b0;
      wait_clk(HALF);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi[m] = data[i];
        wait_clk(HALF);
        rx = {rx[62:0], miso[m]};
        sclk[m] = ~sclk[m];
        wait_clk(HALF);
        sclk[m] = ~sclk[m];
      end else begin
        sclk[m] = ~sclk[m];
        mosi[m] = data[i];
        wait_clk(HALF);
        rx = {rx[62:0], miso[m]};
        sclk[m] = ~sclk[m];
        wait_clk(HALF);
      end
    end
    if (close) begin
      wait_clk(HALF);
      cs_n[m] = 1'b1;
      wait_clk(SETTLE);
    end
  endtask

  task automatic do_frame(input int m, input logic [63:0] data, input int nbits);
    logic [63:0] rx;
    send_bits(m, data, nbits, 1'b1, 1'b1, rx);
    model_frame(m, data, nbits);
    check_all(m);
  endtask

  initial begin
    logic [63:0] rx;
    logic [15:0] rb_exp;
    int          m;
    int          nb;

    rst_n = 1'b0;
    sclk  = 4'b1100;
    mosi  = 4'b0000;
    cs_n  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      dv_cnt[k] = 0; ferr_cnt[k] = 0; exp_dv[k] = 0; exp_ferr[k] = 0;
    end
    model_reset();
    wait_clk(3);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rst_word_m%0d", k), word[k], 16'h0);
      check_eq($sformatf("rst_flags_m%0d", k), {dv[k], ferr[k], busy[k], miso[k]}, 4'h0);
      check_eq($sformatf("rst_errc_m%0d", k), errc[k], 8'h0);
    end
    rst_n = 1'b1;
    wait_clk(SETTLE);

    // Good word sent as two bytes under one CS_n low.
    do_frame(0, 64'h9E23, 16);
`ifdef SPI_SLAVE_MISO_EN
    rb_exp = exp_word[0];
    send_bits(0, 64'h0, 16, 1'b1, 1'b1, rx);
    model_frame(0, 64'h0, 16);
    check_eq("miso_readback", rx[15:0], rb_exp);
    check_all(0);
`endif
    do_frame(0, 64'hABC, 12);
    do_frame(0, 64'hF1234, 20);
    do_frame(0, 64'h0, 0);
    do_frame(0, 64'h1234, 16);

    // Reset mid-frame, then finish that frame with CS_n still low.
    send_bits(0, 64'h9E23 >> 9, 7, 1'b1, 1'b0, rx);
    check_eq("busy_mid_frame", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_word", word[0], 16'h0);
    check_eq("midrst_flags", {dv[0], ferr[0], busy[0], miso[0]}, 4'h0);
    check_eq("midrst_errc", errc[0], 8'h0);
    model_reset();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(SETTLE);
    send_bits(0, 64'h9E23, 9, 1'b0, 1'b1, rx);
    check_all(0);
    do_frame(0, 64'hFFFF, 16);

    for (int k = 1; k < 4; k++) do_frame(k, 64'hA5C3, 16);

    for (int k = 0; k < 24; k++) begin
      m  = int'($urandom_range(0, 3));
      nb = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(0, 40));
      do_frame(m, {$urandom, $urandom}, nb);
    end

    for (int k = 0; k < 300; k++) begin
      cs_n[0] = 1'b0;
      wait_clk(6);
      cs_n[0] = 1'b1;
      wait_clk(8);
      model_frame(0, 64'h0, 0);
    end
    wait_clk(SETTLE);
    check_all(0);
    check_eq("errc_saturated", errc[0], 8'd255);
    check_eq("dv_and_ferr_together", both_cnt, 0);
`ifndef SPI_SLAVE_MISO_EN
    check_eq("miso_tied_low", miso_hi, 0);
`else
    check_eq("miso_low_when_cs_high", miso_hi, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
